quick_spi_arbiter: RTL and testbench
====================================

Name: quick_spi_arbiter

Overview:
- Shares one quick_spi master between NUM_CLIENTS independent requesters using round-robin arbitration.
- Latches the winning client's length and payload, then drives the master's request, num_data and data inputs.
- Watches the master's chip-select and data_valid to track each transaction, and returns the read data to the winning client with a one-cycle done strobe.
- Includes a watchdog that aborts a transaction the master never completes.

Parameters:
- NUM_CLIENTS, 4, number of requesters, ≥2
- MAX_DATA_LENGTH, 16, bits per device per transaction; must match the quick_spi instance
- NUM_DEVICES, 1, parallel SPI devices; must match the quick_spi instance
- TIMEOUT_CYCLES, 4096, maximum clk_i cycles from spi_request_o assertion to spi_data_valid_i
- Derived localparams: NDW = $clog2(MAX_DATA_LENGTH); DW = MAX_DATA_LENGTH*NUM_DEVICES; IW = $clog2(NUM_CLIENTS)

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- cl_req_i  in  NUM_CLIENTS  level request, one bit per client
- cl_num_data_i  in  NUM_CLIENTS*NDW  per-client transfer length, packed with client k at [k*NDW +: NDW]
- cl_data_i  in  NUM_CLIENTS*DW  per-client write payload, packed with client k at [k*DW +: DW]
- cl_gnt_o  out  NUM_CLIENTS  one-hot grant
- cl_done_o  out  NUM_CLIENTS  one-cycle completion strobe to the granted client
- cl_timeout_o  out  1  one-cycle strobe, coincident with cl_done_o, when the transaction was aborted
- cl_data_o  out  DW  read data captured at completion, shared by all clients
- spi_request_o  out  1  to quick_spi request_i
- spi_num_data_o  out  NDW  to quick_spi num_data_i
- spi_data_o  out  DW  to quick_spi data_i
- spi_cs_n_i  in  1  from quick_spi cs_n_o
- spi_data_valid_i  in  1  from quick_spi data_valid_o
- spi_data_i  in  DW  from quick_spi data_o

Behaviour:
- Reset is asynchronous on falling rst_n_i. All outputs go to 0, the state goes to IDLE, and the round-robin pointer goes to NUM_CLIENTS-1, so client 0 has priority first.
- Reset asserted mid-transaction aborts the transaction with no done strobe. Any transfer already started in quick_spi is abandoned.
- All outputs are registered.
- States:
  - IDLE: if cl_req_i != 0, pick the winner = first set bit scanning upward from pointer+1, with wrap-around. Latch its index, load spi_num_data_o and spi_data_o from its slices, set cl_gnt_o to its one-hot bit, and go to REQ. The cycle after the request is seen, cl_gnt_o is asserted.
  - REQ: spi_request_o=1 and held until spi_cs_n_i==0 is sampled. On that cycle, drop spi_request_o and go to BUSY. Holding the request covers quick_spi's post-reset RESET state.
  - BUSY: wait for spi_data_valid_i==1. On that cycle, capture spi_data_i into cl_data_o and go to DONE.
  - DONE: pulse cl_done_o[idx] for exactly 1 cycle, clear cl_gnt_o, set pointer=idx, and go to IDLE.
- Latency: a request seen in IDLE at cycle 0 gives the grant at cycle 1, spi_request_o at cycle 2, and cl_done_o at cycle (valid+2), where valid is the cycle spi_data_valid_i is high.
- spi_request_o is guaranteed low before quick_spi reaches SAMPLE_STROBE, so the master never auto-chains a transaction.
- spi_num_data_o and spi_data_o stay stable from GRANT until the next IDLE winner; client inputs are don't-care after latching.
- A client dropping cl_req_i mid-transaction has no effect; the transaction completes and done is still pulsed.
- A client that keeps cl_req_i high after done re-requests. It wins again only if no other client is requesting.
- Fairness: each requesting client is serviced within NUM_CLIENTS transactions.
- Watchdog: a counter runs from 0 in REQ and BUSY. On reaching TIMEOUT_CYCLES-1:
  - go to DONE;
  - cl_timeout_o=1 alongside cl_done_o;
  - cl_data_o=0;
  - spi_request_o=0.
- spi_data_valid_i seen outside BUSY is ignored.
- spi_cs_n_i low seen in IDLE is ignored.

Decomposition:
- Shared package quick_spi_pkg holds:
  - the arbiter state encoding (IDLE=2'd0, REQ=2'd1, BUSY=2'd2, DONE=2'd3);
  - the width helpers NDW and DW.
- One sub-module, rr_picker: purely combinational. Inputs are req and pointer; outputs are a valid flag and the winner index. It is reusable by later arbiters.
- The watchdog counter and FSM stay inline.

Test Plan:
- Single client: cl_req_i=4'b0001, len=8, data=16'hA5C3; quick_spi model echoes 16'h1234. Required: cl_gnt_o=0001 at cycle 1; spi_request_o held until cs_n falls; cl_done_o=0001 for 1 cycle with cl_data_o=16'h1234; cl_timeout_o=0.
- Round-robin: cl_req_i=4'b1111 held for 8 transactions. Required grant order 0,1,2,3,0,1,2,3, with spi_data_o matching each winner's slice.
- Wrap and skip: pointer=2 after servicing client 2, then cl_req_i=4'b0101. Required next grant is client 0; client 2 is granted only after that.
- Post-reset request: release rst_n_i and assert a request on the same cycle, with the model keeping cs_n high for 5 cycles. Required: spi_request_o stays high through all 5 cycles, and exactly one transaction runs.
- Timeout: TIMEOUT_CYCLES=32 and the model never asserts valid. Required: cl_done_o and cl_timeout_o pulse at cycle 32 after spi_request_o rises, with cl_data_o=0, then the next client is granted.
- Async reset mid-BUSY: assert rst_n_i low. Required: all outputs are 0 within the same cycle with no clock edge, no done strobe, and client 0 has priority after release.

Source files
------------

// File: rtl/quick_spi_pkg.sv
// Shared types and width helpers for the quick_spi arbiter family.
package quick_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  function automatic int calc_ndw(input int max_len);
    return $clog2(max_len);
  endfunction

  function automatic int calc_dw(input int max_len, input int n_dev);
    return max_len * n_dev;
  endfunction

endpackage

// File: rtl/quick_spi_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request above i_ptr, wrapping.
module rr_picker #(
  parameter int N  = 4,
  localparam int IW = $clog2(N)
)(
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_j;

  // Scan from the farthest offset down so the nearest requester above the pointer wins.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    w_j     = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) o_idx = w_j;
    end
  end

endmodule

// File: rtl/quick_spi_arbiter.sv
// Round-robin sharing of one quick_spi master among NUM_CLIENTS requesters, with watchdog.
module quick_spi_arbiter
  import quick_spi_pkg::*;
#(
  parameter int NUM_CLIENTS     = 4,
  parameter int MAX_DATA_LENGTH = 16,
  parameter int NUM_DEVICES     = 1,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int NDW = calc_ndw(MAX_DATA_LENGTH),
  localparam int DW  = calc_dw(MAX_DATA_LENGTH, NUM_DEVICES),
  localparam int IW  = $clog2(NUM_CLIENTS)
)(
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_CLIENTS-1:0]     cl_req_i,
  input  logic [NUM_CLIENTS*NDW-1:0] cl_num_data_i,
  input  logic [NUM_CLIENTS*DW-1:0]  cl_data_i,
  output logic [NUM_CLIENTS-1:0]     cl_gnt_o,
  output logic [NUM_CLIENTS-1:0]     cl_done_o,
  output logic                       cl_timeout_o,
  output logic [DW-1:0]              cl_data_o,
  output logic                       spi_request_o,
  output logic [NDW-1:0]             spi_num_data_o,
  output logic [DW-1:0]              spi_data_o,
  input  logic                       spi_cs_n_i,
  input  logic                       spi_data_valid_i,
  input  logic [DW-1:0]              spi_data_i
);

  localparam int            CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_e             r_state, w_state_n;
  logic [IW-1:0]          r_idx, w_idx_n, r_ptr, w_ptr_n;
  logic [CW-1:0]          r_cnt, w_cnt_n;
  logic                   r_to, w_to_n;
  logic [NUM_CLIENTS-1:0] r_gnt, w_gnt_n, r_done, w_done_n;
  logic                   r_timeout, w_timeout_n;
  logic [DW-1:0]          r_cl_data, w_cl_data_n, r_spi_data, w_spi_data_n;
  logic                   r_spi_req, w_spi_req_n;
  logic [NDW-1:0]         r_spi_num, w_spi_num_n;
  logic                   w_pick_vld, w_wd_hit;
  logic [IW-1:0]          w_pick_idx;

  rr_picker #(.N(NUM_CLIENTS)) u_pick (
    .i_req   (cl_req_i),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  assign w_wd_hit = (r_cnt == WD_LAST);

  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_ptr_n      = r_ptr;
    w_cnt_n      = r_cnt;
    w_to_n       = r_to;
    w_gnt_n      = r_gnt;
    w_done_n     = '0;
    w_timeout_n  = 1'b0;
    w_cl_data_n  = r_cl_data;
    w_spi_req_n  = r_spi_req;
    w_spi_num_n  = r_spi_num;
    w_spi_data_n = r_spi_data;
    case (r_state)
      IDLE: if (w_pick_vld) begin
        w_idx_n      = w_pick_idx;
        w_spi_num_n  = cl_num_data_i[int'(w_pick_idx)*NDW +: NDW];
        w_spi_data_n = cl_data_i[int'(w_pick_idx)*DW +: DW];
        w_gnt_n      = NUM_CLIENTS'(1) << w_pick_idx;
        w_cnt_n      = '0;
        w_to_n       = 1'b0;
        w_state_n    = REQ;
      end
      // Request is held until chip-select falls, which rides out the master's reset state.
      REQ: begin
        w_cnt_n = r_cnt + CW'(1);
        if (w_wd_hit) begin
          w_spi_req_n = 1'b0;
          w_to_n      = 1'b1;
          w_cl_data_n = '0;
          w_state_n   = DONE;
        end else if (r_spi_req && !spi_cs_n_i) begin
          w_spi_req_n = 1'b0;
          w_state_n   = BUSY;
        end else begin
          w_spi_req_n = 1'b1;
        end
      end
      BUSY: begin
        w_cnt_n = r_cnt + CW'(1);
        if (spi_data_valid_i) begin
          w_cl_data_n = spi_data_i;
          w_state_n   = DONE;
        end else if (w_wd_hit) begin
          w_to_n      = 1'b1;
          w_cl_data_n = '0;
          w_state_n   = DONE;
        end
      end
      DONE: begin
        w_done_n    = r_gnt;
        w_timeout_n = r_to;
        w_gnt_n     = '0;
        w_ptr_n     = r_idx;
        w_state_n   = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_ptr      <= IW'(NUM_CLIENTS - 1);
      r_cnt      <= '0;
      r_to       <= 1'b0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_timeout  <= 1'b0;
      r_cl_data  <= '0;
      r_spi_req  <= 1'b0;
      r_spi_num  <= '0;
      r_spi_data <= '0;
    end else begin
      r_state    <= w_state_n;
      r_idx      <= w_idx_n;
      r_ptr      <= w_ptr_n;
      r_cnt      <= w_cnt_n;
      r_to       <= w_to_n;
      r_gnt      <= w_gnt_n;
      r_done     <= w_done_n;
      r_timeout  <= w_timeout_n;
      r_cl_data  <= w_cl_data_n;
      r_spi_req  <= w_spi_req_n;
      r_spi_num  <= w_spi_num_n;
      r_spi_data <= w_spi_data_n;
    end
  end

  assign cl_gnt_o       = r_gnt;
  assign cl_done_o      = r_done;
  assign cl_timeout_o   = r_timeout;
  assign cl_data_o      = r_cl_data;
  assign spi_request_o  = r_spi_req;
  assign spi_num_data_o = r_spi_num;
  assign spi_data_o     = r_spi_data;

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Randomized self-checking bench for quick_spi_arbiter with a behavioural quick_spi slave model.
module tb_quick_spi_arbiter;

  localparam int NC = 4;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cl_req = '0;
  logic [15:0] cl_num_data = '0;
  logic [63:0] cl_data = '0;
  logic [3:0]  cl_gnt, cl_done;
  logic        cl_timeout;
  logic [15:0] cl_rdata;
  logic        spi_req;
  logic [3:0]  spi_num;
  logic [15:0] spi_wdata;
  logic        spi_cs_n, spi_dv;
  logic [15:0] spi_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tb_ptr = NC - 1;

  int          m_cs_delay = 0;
  int          m_xfer = 2;
  int          m_count = 0;
  bit          m_never_valid = 0;
  bit          m_fixed_en = 0;
  logic [15:0] m_fixed = '0;
  logic [15:0] m_resp = '0;
  logic [15:0] m_cap_data = '0;
  logic [3:0]  m_cap_len = '0;

  logic [3:0]  pl_len [NC];
  logic [15:0] pl_dat [NC];

  quick_spi_arbiter #(
    .NUM_CLIENTS(NC), .MAX_DATA_LENGTH(16), .NUM_DEVICES(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cl_req_i(cl_req), .cl_num_data_i(cl_num_data), .cl_data_i(cl_data),
    .cl_gnt_o(cl_gnt), .cl_done_o(cl_done), .cl_timeout_o(cl_timeout), .cl_data_o(cl_rdata),
    .spi_request_o(spi_req), .spi_num_data_o(spi_num), .spi_data_o(spi_wdata),
    .spi_cs_n_i(spi_cs_n), .spi_data_valid_i(spi_dv), .spi_data_i(spi_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // quick_spi slave: cs_n falls m_cs_delay cycles after a request, valid after m_xfer more.
  initial begin
    spi_cs_n = 1'b1; spi_dv = 1'b0; spi_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && spi_req) begin
        for (int i = 0; i < m_cs_delay; i++) begin @(posedge clk); #1; end
        spi_cs_n = 1'b0;
        m_count++;
        m_cap_data = spi_wdata;
        m_cap_len = spi_num;
        for (int i = 0; i < m_xfer; i++) begin @(posedge clk); #1; end
        if (!m_never_valid) begin
          m_resp = m_fixed_en ? m_fixed : 16'($urandom);
          spi_rdata = m_resp;
          spi_dv = 1'b1;
          @(posedge clk); #1;
          spi_dv = 1'b0;
          spi_rdata = 16'($urandom);
        end
        spi_cs_n = 1'b1;
      end
    end
  end

  function automatic int ref_pick(input logic [3:0] m, input int p);
    for (int k = 1; k <= NC; k++)
      if (((m >> ((p + k) % NC)) & 4'd1) != 4'd0) return (p + k) % NC;
    return -1;
  endfunction

  task automatic set_payloads();
    for (int k = 0; k < NC; k++) begin
      pl_len[k] = 4'($urandom_range(1, 15));
      pl_dat[k] = 16'($urandom);
      cl_num_data[k*4 +: 4] = pl_len[k];
      cl_data[k*16 +: 16] = pl_dat[k];
    end
  endtask

  // Waits for a done strobe; also reports how long the request stayed up before cs_n fell.
  task automatic wait_done(output bit ok, output int hi, output bit dropped);
    bit seen, cs_fell;
    ok = 0; hi = 0; dropped = 0; seen = 0; cs_fell = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!spi_cs_n) cs_fell = 1;
      if (spi_req && spi_cs_n && !cs_fell) begin hi++; seen = 1; end
      else if (seen && !cs_fell && !spi_req) dropped = 1;
      if (cl_done != '0) begin ok = 1; break; end
    end
  endtask

  task automatic apply_reset();
    cl_req = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tb_ptr = NC - 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cl_gnt, cl_done, cl_timeout, cl_rdata} !== '0)
      $display("FAIL reset_client_outs: got %h want 0", {cl_gnt, cl_done, cl_timeout, cl_rdata});
    checks++;
    if ({spi_req, spi_num, spi_wdata} !== '0)
      $display("FAIL reset_spi_outs: got %h want 0", {spi_req, spi_num, spi_wdata});
    if ({cl_gnt, cl_done, cl_timeout, cl_rdata, spi_req, spi_num, spi_wdata} !== '0) errors++;
    rst_n = 1'b1;
    tb_ptr = NC - 1;
  endtask

  task automatic test_single();
    bit ok, dropped; int hi;
    set_payloads();
    cl_num_data[3:0] = 4'd8;
    cl_data[15:0] = 16'hA5C3;
    m_fixed_en = 1; m_fixed = 16'h1234; m_cs_delay = 2; m_xfer = 3;
    @(negedge clk); cl_req = 4'b0001;
    @(negedge clk);
    checks++; if (cl_gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", cl_gnt); end
    cl_req = '0;
    set_payloads();
    @(negedge clk);
    checks++; if (spi_req !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", spi_req); end
    wait_done(ok, hi, dropped);
    checks++; if (!ok) begin errors++; $display("FAIL single_wait: no done within bound"); end
    checks++; if (dropped) begin errors++; $display("FAIL single_req_hold: request dropped before cs_n fell"); end
    checks++; if (cl_done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", cl_done); end
    checks++; if (cl_rdata !== 16'h1234) begin errors++; $display("FAIL single_rdata: got %h want 1234", cl_rdata); end
    checks++; if (cl_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b want 0", cl_timeout); end
    checks++;
    if (m_cap_data !== 16'hA5C3 || m_cap_len !== 4'd8) begin
      errors++; $display("FAIL single_payload: got %h/%0d want a5c3/8", m_cap_data, m_cap_len);
    end
    @(negedge clk);
    checks++;
    if (cl_done !== 4'b0000 || cl_gnt !== 4'b0000) begin
      errors++; $display("FAIL single_done_pulse: done %b gnt %b want 0000/0000", cl_done, cl_gnt);
    end
    m_fixed_en = 0;
    tb_ptr = 0;
  endtask

  // Back-to-back transactions; mask is 1111 throughout or re-randomized at each done.
  task automatic test_arbitration(input int n, input bit rnd);
    bit ok, dropped; int hi, win;
    logic [3:0] mask, e_len;
    logic [15:0] e_dat;
    set_payloads();
    mask = rnd ? 4'($urandom_range(1, 15)) : 4'hF;
    cl_req = mask;
    for (int t = 0; t < n; t++) begin
      win = ref_pick(mask, tb_ptr);
      e_len = pl_len[win];
      e_dat = pl_dat[win];
      if (rnd) begin m_cs_delay = $urandom_range(0, 3); m_xfer = $urandom_range(1, 6); end
      else begin m_cs_delay = 0; m_xfer = 2; end
      @(negedge clk);
      checks++;
      if (cl_gnt !== 4'(1 << win)) begin
        errors++; $display("FAIL arb_gnt t=%0d: got %b want %b", t, cl_gnt, 4'(1 << win));
      end
      set_payloads();
      if (rnd) cl_req = 4'($urandom);
      wait_done(ok, hi, dropped);
      checks++;
      if (!ok || cl_done !== 4'(1 << win)) begin
        errors++; $display("FAIL arb_done t=%0d: got %b want %b", t, cl_done, 4'(1 << win));
      end
      checks++;
      if (m_cap_data !== e_dat || m_cap_len !== e_len) begin
        errors++; $display("FAIL arb_payload t=%0d: got %h/%0d want %h/%0d", t, m_cap_data, m_cap_len, e_dat, e_len);
      end
      checks++;
      if (cl_rdata !== m_resp || cl_timeout !== 1'b0) begin
        errors++; $display("FAIL arb_rdata t=%0d: got %h/%b want %h/0", t, cl_rdata, cl_timeout, m_resp);
      end
      tb_ptr = win;
      mask = (t == n - 1) ? 4'h0 : (rnd ? 4'($urandom_range(1, 15)) : 4'hF);
      cl_req = mask;
    end
    @(negedge clk);
    checks++; if (cl_done !== 4'b0000) begin errors++; $display("FAIL arb_done_pulse: got %b want 0000", cl_done); end
  endtask

  task automatic test_wrap_skip();
    bit ok, dropped; int hi;
    m_cs_delay = 0; m_xfer = 2;
    cl_req = 4'b0100;
    @(negedge clk); cl_req = '0;
    wait_done(ok, hi, dropped);
    checks++; if (cl_done !== 4'b0100) begin errors++; $display("FAIL wrap_setup: got %b want 0100", cl_done); end
    cl_req = 4'b0101;
    @(negedge clk);
    checks++; if (cl_gnt !== 4'b0001) begin errors++; $display("FAIL wrap_first_gnt: got %b want 0001", cl_gnt); end
    wait_done(ok, hi, dropped);
    checks++; if (cl_done !== 4'b0001) begin errors++; $display("FAIL wrap_first_done: got %b want 0001", cl_done); end
    @(negedge clk);
    checks++; if (cl_gnt !== 4'b0100) begin errors++; $display("FAIL wrap_second_gnt: got %b want 0100", cl_gnt); end
    cl_req = '0;
    wait_done(ok, hi, dropped);
    checks++; if (cl_done !== 4'b0100) begin errors++; $display("FAIL wrap_second_done: got %b want 0100", cl_done); end
    tb_ptr = 2;
  endtask

  task automatic test_timeout();
    bit ok, dropped; int hi, w1, w2, rise;
    m_never_valid = 1; m_cs_delay = 0; m_xfer = 3;
    w1 = ref_pick(4'b0110, tb_ptr);
    w2 = ref_pick(4'b0110, w1);
    cl_req = 4'b0110;
    rise = -1; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spi_req && rise < 0) rise = cyc;
      if (cl_done != '0) begin ok = 1; break; end
    end
    checks++;
    if (!ok || cyc - rise != TO) begin
      errors++; $display("FAIL to_latency: got %0d want %0d (done seen %b)", cyc - rise, TO, ok);
    end
    checks++;
    if (cl_done !== 4'(1 << w1) || cl_timeout !== 1'b1) begin
      errors++; $display("FAIL to_strobe: got %b/%b want %b/1", cl_done, cl_timeout, 4'(1 << w1));
    end
    checks++;
    if (cl_rdata !== 16'h0 || spi_req !== 1'b0) begin
      errors++; $display("FAIL to_clear: got %h/%b want 0000/0", cl_rdata, spi_req);
    end
    m_never_valid = 0;
    @(negedge clk);
    checks++;
    if (cl_timeout !== 1'b0 || cl_gnt !== 4'(1 << w2)) begin
      errors++; $display("FAIL to_next_gnt: got %b/%b want 0/%b", cl_timeout, cl_gnt, 4'(1 << w2));
    end
    cl_req = '0;
    wait_done(ok, hi, dropped);
    checks++;
    if (cl_done !== 4'(1 << w2) || cl_timeout !== 1'b0) begin
      errors++; $display("FAIL to_recover: got %b/%b want %b/0", cl_done, cl_timeout, 4'(1 << w2));
    end
    tb_ptr = w2;
  endtask

  task automatic test_post_reset();
    bit ok, dropped, extra; int hi, cnt0;
    cl_req = '0; rst_n = 1'b0;
    m_cs_delay = 5; m_xfer = 2;
    repeat (2) @(negedge clk);
    cnt0 = m_count;
    rst_n = 1'b1; cl_req = 4'b0001; tb_ptr = NC - 1;
    @(negedge clk);
    checks++; if (cl_gnt !== 4'b0001) begin errors++; $display("FAIL post_rst_gnt: got %b want 0001", cl_gnt); end
    cl_req = '0;
    wait_done(ok, hi, dropped);
    checks++;
    if (!ok || hi < 5 || dropped) begin
      errors++; $display("FAIL post_rst_hold: done %b high_cycles %0d dropped %b want 1/>=5/0", ok, hi, dropped);
    end
    extra = 0;
    repeat (40) begin @(negedge clk); if (spi_req || cl_done != '0) extra = 1; end
    checks++;
    if (extra || m_count != cnt0 + 1) begin
      errors++; $display("FAIL post_rst_single: txns %0d want 1, extra activity %b", m_count - cnt0, extra);
    end
    tb_ptr = 0; m_cs_delay = 0;
  endtask

  task automatic test_async_reset();
    bit ok, dropped, bad; int hi;
    m_cs_delay = 0; m_xfer = 20;
    cl_req = 4'b0100;
    @(negedge clk);
    checks++; if (cl_gnt !== 4'b0100) begin errors++; $display("FAIL arst_gnt: got %b want 0100", cl_gnt); end
    cl_req = '0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (!spi_cs_n) begin ok = 1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL arst_busy: cs_n never fell"); end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cl_gnt, cl_done, cl_timeout, cl_rdata, spi_req, spi_num, spi_wdata} !== '0) begin
      errors++; $display("FAIL arst_outs: got %h want 0", {cl_gnt, cl_done, cl_timeout, cl_rdata, spi_req, spi_num, spi_wdata});
    end
    bad = 0;
    repeat (30) begin @(negedge clk); if (cl_done != '0 || spi_req) bad = 1; end
    checks++; if (bad) begin errors++; $display("FAIL arst_no_done: strobe or request seen in reset"); end
    m_xfer = 2;
    rst_n = 1'b1; cl_req = 4'b1111; tb_ptr = NC - 1;
    @(negedge clk);
    checks++; if (cl_gnt !== 4'b0001) begin errors++; $display("FAIL arst_priority: got %b want 0001", cl_gnt); end
    cl_req = '0;
    wait_done(ok, hi, dropped);
    checks++; if (cl_done !== 4'b0001) begin errors++; $display("FAIL arst_resume: got %b want 0001", cl_done); end
    tb_ptr = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    apply_reset();
    test_arbitration(8, 1'b0);
    test_wrap_skip();
    test_arbitration(20, 1'b1);
    test_timeout();
    test_post_reset();
    test_async_reset();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
